// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared widths, register indices and types for the GPR file
package gpr_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int GPR_NUM    = 2 ** GPR_ADDR_W;
  localparam int GPR_OF_REG = 30;
  localparam int GPR_ZERO   = 0;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
  typedef logic [GPR_DATA_W-1:0] gpr_data_t;

endpackage

// File: rtl/gpr_read_port.sv
// rtl/gpr_read_port.sv - async read port: $0 forced to zero, optional same-cycle write forwarding
// Forwarding is compiled in only when GPR_WRITE_BYPASS_EN is defined.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W
`ifdef GPR_WRITE_BYPASS_EN
  , parameter int OF_REG = GPR_OF_REG
`endif
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] arr_data_i,
`ifdef GPR_WRITE_BYPASS_EN
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              of_wr_en_i,
  input  logic              of_flag_i,
`endif
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(GPR_ZERO);
`ifdef GPR_WRITE_BYPASS_EN
  localparam logic [ADDR_W-1:0] OF_ADDR = ADDR_W'(OF_REG);
`endif

  always_comb begin
    rd_data_o = arr_data_i;
`ifdef GPR_WRITE_BYPASS_EN
    if (we_i && (wr_addr_i == rd_addr_i)) rd_data_o = wr_data_i;
    // the flag update lands on bit 0 even when the data write is trapped
    if (of_wr_en_i && (rd_addr_i == OF_ADDR)) rd_data_o[0] = of_flag_i;
`endif
    if (rd_addr_i == ZERO_ADDR) rd_data_o = '0;
  end

endmodule

// File: rtl/gpr_regfile.sv
// rtl/gpr_regfile.sv - 32x32 MIPS GPR file with overflow-trapped writes and flag in $OF_REG[0]
// Define GPR_WRITE_BYPASS_EN to forward same-cycle writes onto both read ports.
module gpr_regfile
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int OF_REG = GPR_OF_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WrEn,
  input  logic              OFWrEn,
  input  logic              OFFlag,
  input  logic [ADDR_W-1:0] RdAddr1,
  input  logic [ADDR_W-1:0] RdAddr2,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData1,
  output logic [DATA_W-1:0] RdData2
);

  localparam int NUM = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] OF_ADDR = ADDR_W'(OF_REG);

  logic [DATA_W-1:0] regs_q [NUM];
  logic [DATA_W-1:0] regs_d [NUM];
  logic              we;

  assign we = WrEn & ~(OFWrEn & OFFlag);

  // flag update is applied after the data write so it owns bit 0 on a collision
  always_comb begin
    regs_d = regs_q;
    if (we && (WrAddr != '0)) regs_d[WrAddr] = WrData;
    if (OFWrEn) regs_d[OF_ADDR][0] = OFFlag;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  gpr_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
`ifdef GPR_WRITE_BYPASS_EN
    , .OF_REG(OF_REG)
`endif
  ) u_rd1 (
    .rd_addr_i (RdAddr1),
    .arr_data_i(regs_q[RdAddr1]),
`ifdef GPR_WRITE_BYPASS_EN
    .we_i      (we),
    .wr_addr_i (WrAddr),
    .wr_data_i (WrData),
    .of_wr_en_i(OFWrEn),
    .of_flag_i (OFFlag),
`endif
    .rd_data_o (RdData1)
  );

  gpr_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
`ifdef GPR_WRITE_BYPASS_EN
    , .OF_REG(OF_REG)
`endif
  ) u_rd2 (
    .rd_addr_i (RdAddr2),
    .arr_data_i(regs_q[RdAddr2]),
`ifdef GPR_WRITE_BYPASS_EN
    .we_i      (we),
    .wr_addr_i (WrAddr),
    .wr_data_i (WrData),
    .of_wr_en_i(OFWrEn),
    .of_flag_i (OFFlag),
`endif
    .rd_data_o (RdData2)
  );

endmodule

// File: tb/tb_gpr_regfile.sv
// tb/tb_gpr_regfile.sv - scoreboard bench for gpr_regfile (directed vectors)
module tb_gpr_regfile;
  import gpr_pkg::*;

  logic      clk = 1'b0;
  logic      rst, WrEn, OFWrEn, OFFlag;
  gpr_addr_t RdAddr1, RdAddr2, WrAddr;
  gpr_data_t WrData, RdData1, RdData2;

  always #5 clk = ~clk;

  gpr_regfile dut (
    .clk(clk), .rst(rst), .WrEn(WrEn), .OFWrEn(OFWrEn), .OFFlag(OFFlag),
    .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .WrAddr(WrAddr), .WrData(WrData),
    .RdData1(RdData1), .RdData2(RdData2)
  );

  typedef struct {
    string     name;
    logic      port;
    gpr_data_t val;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  gpr_data_t m_act;
  int checks = 0;
  int errors = 0;

`ifdef GPR_WRITE_BYPASS_EN
  localparam gpr_data_t BYP_PRE = 32'hA5A5A5A5;
`else
  localparam gpr_data_t BYP_PRE = 32'h12345650;
`endif

  function automatic gpr_data_t fill_val(input int i);
    return (32'(i) << 3) ^ 32'h12345678;
  endfunction

  // Monitor: inputs are driven just after posedge, read ports are settled by negedge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_act = m_e.port ? RdData2 : RdData1;
      checks++;
      if (m_act !== m_e.val) begin
        errors++;
        $display("FAIL %s RdData%0d: got %h expected %h", m_e.name, m_e.port + 1, m_act, m_e.val);
      end
    end
  end

  task automatic step(input logic r, input logic we, input logic ofwe, input logic off,
                      input gpr_addr_t wa, input gpr_data_t wd,
                      input gpr_addr_t a1, input gpr_addr_t a2,
                      input gpr_data_t e1, input gpr_data_t e2,
                      input string nm, input bit chk);
    @(posedge clk);
    #1;
    rst = r; WrEn = we; OFWrEn = ofwe; OFFlag = off;
    WrAddr = wa; WrData = wd; RdAddr1 = a1; RdAddr2 = a2;
    if (chk) begin
      exp_q.push_back('{name: nm, port: 1'b0, val: e1});
      exp_q.push_back('{name: nm, port: 1'b1, val: e2});
    end
  endtask

  task automatic rd(input gpr_addr_t a1, input gpr_addr_t a2,
                    input gpr_data_t e1, input gpr_data_t e2, input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, a1, a2, e1, e2, nm, 1'b1);
  endtask

  initial begin
    // reset asserted while a write is also requested: reset must win
    rst = 1'b1; WrEn = 1'b1; OFWrEn = 1'b1; OFFlag = 1'b1;
    WrAddr = 5'd3; WrData = 32'hDEADBEEF; RdAddr1 = 5'd0; RdAddr2 = 5'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_clear");

    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'(i), fill_val(i), 5'd0, 5'd0, 32'h0, 32'h0, "fill_wr", 1'b1);
      rd(5'(i), (i == 0) ? 5'd0 : 5'(i - 1),
         (i == 0) ? 32'h0 : fill_val(i),
         (i <= 1) ? 32'h0 : fill_val(i - 1), "fill_rd");
    end

    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 32'h87654321, 5'd0, 5'd0, 32'h0, 32'h0, "of_ok_wr", 1'b1);
    rd(5'd1, 5'd30, 32'h87654321, 32'h12345688, "of_ok");

    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h87654321, 5'd0, 5'd0, 32'h0, 32'h0, "of_trap_wr", 1'b1);
    rd(5'd2, 5'd30, 32'h12345668, 32'h12345689, "of_trap");

    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd30, 32'hFFFFFFFE, 5'd0, 5'd0, 32'h0, 32'h0, "coll_wr", 1'b1);
    rd(5'd30, 5'd1, 32'hFFFFFFFE, 32'h87654321, "collision");
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd30, 32'h00000001, 5'd0, 5'd0, 32'h0, 32'h0, "plain30_wr", 1'b1);
    rd(5'd30, 5'd30, 32'h00000001, 32'h00000001, "plain30");
    // flag update with WrEn low only touches bit 0
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0BADF00D, 5'd0, 5'd0, 32'h0, 32'h0, "flag_only_wr", 1'b1);
    rd(5'd30, 5'd7, 32'h00000000, fill_val(7), "flag_only");

    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd5, BYP_PRE, BYP_PRE, "bypass_pre", 1'b1);
    rd(5'd5, 5'd0, 32'hA5A5A5A5, 32'h0, "bypass_post");

    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h11111111, 5'd0, 5'd0, 32'h0, 32'h0, "rst2", 1'b0);
    rd(5'd5, 5'd9, 32'h0, 32'h0, "reset_again");
    rd(5'd30, 5'd1, 32'h0, 32'h0, "reset_again2");

    @(negedge clk);
    #1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
